// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: instruction classes,
// instruction names and the entry bundle carried on issue and dispatch.
package reservation_station_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        AL = 3'd0,
        BR = 3'd1,
        LS = 3'd2,
        RB = 3'd3,
        MD = 3'd4
    } instr_type_e;

    typedef enum logic [3:0] {
        UNKNOWN = 4'd0,
        I_ADD   = 4'd1,
        I_SUB   = 4'd2,
        I_AND   = 4'd3,
        I_OR    = 4'd4,
        I_XOR   = 4'd5,
        I_SLL   = 4'd6,
        I_SRL   = 4'd7,
        I_BEQ   = 4'd8,
        I_BNE   = 4'd9,
        I_LW    = 4'd10,
        I_SW    = 4'd11,
        I_MUL   = 4'd12,
        I_DIV   = 4'd13
    } instr_name_e;

    typedef struct packed {
        instr_type_e        instr_type;
        instr_name_e        instr_name;
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  imm;
        logic [TAG_W-1:0]   src1_tag;
        logic [DATA_W-1:0]  src1_val;
        logic               src1_rdy;
        logic [TAG_W-1:0]   src2_tag;
        logic [DATA_W-1:0]  src2_val;
        logic               src2_rdy;
        logic [TAG_W-1:0]   dst_tag;
    } rs_entry_t;

    function automatic logic both_ready(input rs_entry_t e);
        return e.src1_rdy & e.src2_rdy;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and dispatch signals of one reservation station.
interface reservation_station_if
    import reservation_station_pkg::*;
#(
    parameter int XLEN = 32
);
    logic [1:0]             in_valid;
    rs_entry_t [1:0]        in_entry;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [XLEN-1:0]        cdb_data;
    logic                   out_valid;
    rs_entry_t              out_entry;
    logic                   out_ready;
    logic                   full;
    logic                   empty;

    modport master (
        output in_valid, in_entry,
        output cdb_valid, cdb_tag, cdb_data,
        output out_ready,
        input  out_valid, out_entry,
        input  full, empty
    );

    modport slave (
        input  in_valid, in_entry,
        input  cdb_valid, cdb_tag, cdb_data,
        input  out_ready,
        output out_valid, out_entry,
        output full, empty
    );
endinterface

// File: rtl/reservation_station_wakeup.sv
// Per-entry CDB tag compare: marks a waiting operand ready and
// captures the broadcast value.
module rs_wakeup
    import reservation_station_pkg::*;
(
    input  rs_entry_t          ent_i,
    input  logic               cdb_valid_i,
    input  logic [TAG_W-1:0]   cdb_tag_i,
    input  logic [DATA_W-1:0]  cdb_data_i,
    output rs_entry_t          ent_o
);
    logic hit1;
    logic hit2;

    assign hit1 = cdb_valid_i && !ent_i.src1_rdy
               && (ent_i.src1_tag == cdb_tag_i);
    assign hit2 = cdb_valid_i && !ent_i.src2_rdy
               && (ent_i.src2_tag == cdb_tag_i);

    always_comb begin
        ent_o = ent_i;
        if (hit1) begin
            ent_o.src1_rdy = 1'b1;
            ent_o.src1_val = cdb_data_i;
        end
        if (hit2) begin
            ent_o.src2_rdy = 1'b1;
            ent_o.src2_val = cdb_data_i;
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Age-ordered collapsing reservation station: dual issue in, CDB wakeup,
// oldest-ready single dispatch out.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int          SIZE    = 8,
    parameter instr_type_e RS_TYPE = AL
) (
    input logic                   clock,
    input logic                   reset,
    input logic                   flush,
    reservation_station_if.slave  rs
);
    localparam int IW = $clog2(SIZE);
    localparam int CW = IW + 1;

    rs_entry_t          ent_q [SIZE];
    rs_entry_t          ent_d [SIZE];
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;

    rs_entry_t          wk  [SIZE];
    rs_entry_t          shf [SIZE];
    rs_entry_t          win [2];

    logic [XLEN-1:0]    cdb_raw;
    logic [DATA_W-1:0]  cdb_data;
    logic               full;
    logic [1:0]         acc;
    logic               found;
    logic [IW-1:0]      sel;
    logic               out_valid;
    logic               removed;
    logic [CW-1:0]      base;

    assign cdb_raw  = rs.cdb_data;
    assign cdb_data = DATA_W'(cdb_raw);

    for (genvar g = 0; g < SIZE; g++) begin : g_ent
        rs_wakeup u_wk (
            .ent_i       (ent_q[g]),
            .cdb_valid_i (rs.cdb_valid),
            .cdb_tag_i   (rs.cdb_tag),
            .cdb_data_i  (cdb_data),
            .ent_o       (wk[g])
        );
        if (g == SIZE - 1) begin : g_top
            assign shf[g] = '0;
        end else begin : g_mid
            assign shf[g] = wk[g+1];
        end
    end

    // Incoming slots see the same broadcast so a same-edge wakeup is kept.
    for (genvar k = 0; k < 2; k++) begin : g_in
        rs_wakeup u_wk (
            .ent_i       (rs.in_entry[k]),
            .cdb_valid_i (rs.cdb_valid),
            .cdb_tag_i   (rs.cdb_tag),
            .cdb_data_i  (cdb_data),
            .ent_o       (win[k])
        );
    end

    assign full     = cnt_q > CW'(SIZE - 2);
    assign rs.full  = full;
    assign rs.empty = (cnt_q == '0);

    always_comb begin
        acc = '0;
        for (int k = 0; k < 2; k++) begin
            acc[k] = rs.in_valid[k]
                  && (rs.in_entry[k].instr_type == RS_TYPE)
                  && (rs.in_entry[k].instr_name != UNKNOWN)
                  && !full && !flush;
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (!found && (i < int'(cnt_q)) && both_ready(ent_q[i])) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    assign out_valid    = found && !flush;
    assign rs.out_valid = out_valid;
    assign rs.out_entry = out_valid ? ent_q[sel] : '0;
    assign removed      = out_valid && rs.out_ready;
    assign base         = cnt_q - CW'(removed);

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            ent_d[i] = '0;
            if (flush) begin
                ent_d[i] = '0;
            end else if (i < int'(base)) begin
                ent_d[i] = (removed && (i >= int'(sel))) ? shf[i] : wk[i];
            end else if (acc[0] && (i == int'(base))) begin
                ent_d[i] = win[0];
            end else if (acc[1] && (i == int'(base) + int'(acc[0]))) begin
                ent_d[i] = win[1];
            end
        end
        cnt_d = base + CW'(acc[0]) + CW'(acc[1]);
        if (flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            ent_q <= ent_d;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed scoreboard bench for the reservation station.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    reservation_station_if #(.XLEN(32)) bus();

    reservation_station #(
        .XLEN    (32),
        .SIZE    (8),
        .RS_TYPE (AL)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .flush (flush),
        .rs    (bus)
    );

    int total = 0;
    int bad   = 0;
    rs_entry_t sb [$];
    rs_entry_t m_exp;
    rs_entry_t nil = '0;

    function automatic rs_entry_t mk(input logic [5:0] dst,
                                     input logic r1, input logic [5:0] t1,
                                     input logic r2, input logic [5:0] t2);
        rs_entry_t e;
        e = '0;
        e.instr_type = AL;
        e.instr_name = I_ADD;
        e.addr       = 32'h1000 + 32'(dst);
        e.imm        = 32'(dst) * 3;
        e.dst_tag    = dst;
        e.src1_tag   = t1;
        e.src1_rdy   = r1;
        e.src1_val   = r1 ? 32'h100 + 32'(dst) : 32'h0;
        e.src2_tag   = t2;
        e.src2_rdy   = r2;
        e.src2_val   = r2 ? 32'h200 + 32'(dst) : 32'h0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL dispatch: unexpected tag %0d",
                         bus.out_entry.dst_tag);
            end else begin
                m_exp = sb.pop_front();
                if (bus.out_entry !== m_exp) begin
                    bad++;
                    $display("FAIL dispatch: got tag %0d s1 %h s2 %h expected tag %0d s1 %h s2 %h",
                             bus.out_entry.dst_tag, bus.out_entry.src1_val,
                             bus.out_entry.src2_val, m_exp.dst_tag,
                             m_exp.src1_val, m_exp.src2_val);
                end
            end
        end
    end

    task automatic issue(input rs_entry_t e0, input bit v0,
                         input rs_entry_t e1, input bit v1);
        bus.in_entry[0] = e0;
        bus.in_entry[1] = e1;
        bus.in_valid    = {v1, v0};
        @(posedge clk);
        #1;
        bus.in_valid    = 2'b00;
    endtask

    task automatic drain(input string nm);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && bus.empty) break;
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        chk({nm, "_empty"}, bus.empty, 1'b1);
        chk({nm, "_sb"}, sb.size(), 0);
    endtask

    rs_entry_t a, b, c, e, f;

    initial begin
        bus.in_valid  = 2'b00;
        bus.in_entry  = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
        bus.out_ready = 1'b0;

        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_out_entry", 64'(bus.out_entry == '0), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single insert, foreign-type slot ignored
        e = mk(6'd1, 1'b1, 6'd0, 1'b1, 6'd0);
        f = mk(6'd2, 1'b1, 6'd0, 1'b1, 6'd0);
        f.instr_type = BR;
        issue(e, 1'b1, f, 1'b1);
        chk("t2_out_valid", bus.out_valid, 1'b1);
        chk("t2_tag", bus.out_entry.dst_tag, 6'd1);
        chk("t2_empty", bus.empty, 1'b0);
        sb.push_back(e);
        drain("t2");
        f = mk(6'd3, 1'b1, 6'd0, 1'b1, 6'd0);
        f.instr_name = UNKNOWN;
        issue(f, 1'b1, nil, 1'b0);
        chk("unk_empty", bus.empty, 1'b1);

        // fill to full, fifth pair dropped
        for (int i = 0; i < 4; i++) begin
            e = mk(6'(10 + 2 * i), 1'b1, 6'd0, 1'b1, 6'd0);
            f = mk(6'(11 + 2 * i), 1'b1, 6'd0, 1'b1, 6'd0);
            issue(e, 1'b1, f, 1'b1);
            sb.push_back(e);
            sb.push_back(f);
            if (i == 2) chk("fill6_full", bus.full, 1'b0);
            if (i == 3) chk("fill8_full", bus.full, 1'b1);
        end
        issue(mk(6'd20, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1,
              mk(6'd21, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1);
        chk("drop_full", bus.full, 1'b1);
        drain("t3");

        // CDB wakeup plus same-edge bypass
        e = mk(6'd30, 1'b0, 6'd5, 1'b1, 6'd0);
        issue(e, 1'b1, nil, 1'b0);
        chk("t4_wait", bus.out_valid, 1'b0);
        f = mk(6'd31, 1'b1, 6'd5, 1'b0, 6'd5);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd5;
        bus.cdb_data  = 32'hDEADBEEF;
        issue(f, 1'b1, nil, 1'b0);
        bus.cdb_valid = 1'b0;
        chk("t4_valid", bus.out_valid, 1'b1);
        chk("t4_tag", bus.out_entry.dst_tag, 6'd30);
        chk("t4_src1", bus.out_entry.src1_val, 32'hDEADBEEF);
        e.src1_rdy = 1'b1;
        e.src1_val = 32'hDEADBEEF;
        f.src2_rdy = 1'b1;
        f.src2_val = 32'hDEADBEEF;
        sb.push_back(e);
        sb.push_back(f);
        drain("t4");

        // younger ready entries bypass a blocked head
        a = mk(6'd40, 1'b0, 6'd9, 1'b1, 6'd0);
        b = mk(6'd41, 1'b1, 6'd0, 1'b1, 6'd0);
        c = mk(6'd42, 1'b1, 6'd0, 1'b1, 6'd0);
        issue(a, 1'b1, b, 1'b1);
        issue(c, 1'b1, nil, 1'b0);
        chk("t5_first", bus.out_entry.dst_tag, 6'd41);
        sb.push_back(b);
        sb.push_back(c);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("t5_blocked", bus.out_valid, 1'b0);
        chk("t5_a_left", bus.empty, 1'b0);
        chk("t5_sb", sb.size(), 0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd9;
        bus.cdb_data  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.cdb_valid = 1'b0;
        chk("t5_a_tag", bus.out_entry.dst_tag, 6'd40);
        a.src1_rdy = 1'b1;
        a.src1_val = 32'h12345678;
        sb.push_back(a);
        drain("t5");

        // two inserts and one dispatch on the same edge
        for (int i = 0; i < 5; i++) begin
            e = mk(6'(50 + i), 1'b1, 6'd0, 1'b1, 6'd0);
            sb.push_back(e);
        end
        issue(sb[0], 1'b1, sb[1], 1'b1);
        issue(sb[2], 1'b1, sb[3], 1'b1);
        issue(sb[4], 1'b1, nil, 1'b0);
        e = mk(6'd55, 1'b1, 6'd0, 1'b1, 6'd0);
        f = mk(6'd56, 1'b1, 6'd0, 1'b1, 6'd0);
        sb.push_back(e);
        sb.push_back(f);
        bus.out_ready = 1'b1;
        issue(e, 1'b1, f, 1'b1);
        bus.out_ready = 1'b0;
        chk("t6_cnt6_full", bus.full, 1'b0);
        chk("t6_head", bus.out_entry.dst_tag, 6'd51);
        e = mk(6'd57, 1'b1, 6'd0, 1'b1, 6'd0);
        f = mk(6'd58, 1'b1, 6'd0, 1'b1, 6'd0);
        sb.push_back(e);
        sb.push_back(f);
        issue(e, 1'b1, f, 1'b1);
        chk("t6_cnt8_full", bus.full, 1'b1);
        drain("t6");

        // flush with pending inserts
        issue(mk(6'd60, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1,
              mk(6'd61, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1);
        issue(mk(6'd62, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1,
              mk(6'd63, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1);
        chk("t7_pre", bus.empty, 1'b0);
        flush = 1'b1;
        bus.in_entry[0] = mk(6'd0, 1'b1, 6'd0, 1'b1, 6'd0);
        bus.in_entry[1] = mk(6'd1, 1'b1, 6'd0, 1'b1, 6'd0);
        bus.in_valid    = 2'b11;
        @(negedge clk);
        chk("t7_flush_ov", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 2'b00;
        chk("t7_empty", bus.empty, 1'b1);
        chk("t7_ov", bus.out_valid, 1'b0);
        chk("t7_full", bus.full, 1'b0);

        // reset in the middle of traffic
        issue(mk(6'd7, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1,
              mk(6'd8, 1'b1, 6'd0, 1'b1, 6'd0), 1'b1);
        chk("t8_pre", bus.empty, 1'b0);
        bus.in_entry[0] = mk(6'd9, 1'b1, 6'd0, 1'b1, 6'd0);
        bus.in_valid    = 2'b01;
        rst_n = 1'b0;
        #2;
        chk("t8_empty", bus.empty, 1'b1);
        chk("t8_ov", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t8_after", bus.empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
